// File: rtl/sc_reg_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : sc_reg_serializer
//  Description : Parallel-in, serial-out transmitter. Captures a word on an
//                active-low load request, shifts it out one bit per clock
//                with a valid strobe, then raises a one-cycle done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module sc_reg_serializer #(
   parameter int RegSERIAL_DATAWIDTH = 8,
   parameter bit RegSERIAL_MSB_FIRST = 1'b1
) (
   input  logic                           SC_RegSERIAL_CLOCK_50,
   input  logic                           SC_RegSERIAL_RESET_InHigh,
   input  logic                           SC_RegSERIAL_clear_InLow,
   input  logic                           SC_RegSERIAL_load_InLow,
   input  logic [RegSERIAL_DATAWIDTH-1:0] SC_RegSERIAL_data_InBUS,
   output logic                           SC_RegSERIAL_ready_Out,
   output logic                           SC_RegSERIAL_serial_Out,
   output logic                           SC_RegSERIAL_valid_Out,
   output logic                           SC_RegSERIAL_done_Out
);

   localparam int c_CW = (RegSERIAL_DATAWIDTH > 1) ? $clog2(RegSERIAL_DATAWIDTH) : 1;
   localparam logic [c_CW-1:0] c_LAST = c_CW'(RegSERIAL_DATAWIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                         r_state, w_stateNext;
   logic [RegSERIAL_DATAWIDTH-1:0] r_shift, w_shiftNext, w_shiftMoved;
   logic [c_CW-1:0]                r_count, w_countNext;
   logic                           w_activeBit;

   // Shift direction and active end bit are fixed by the bit-order parameter.
   generate
      if (RegSERIAL_MSB_FIRST) begin : g_msb_first
         assign w_shiftMoved = {r_shift[RegSERIAL_DATAWIDTH-2:0], 1'b0};
         assign w_activeBit  = r_shift[RegSERIAL_DATAWIDTH-1];
      end else begin : g_lsb_first
         assign w_shiftMoved = {1'b0, r_shift[RegSERIAL_DATAWIDTH-1:1]};
         assign w_activeBit  = r_shift[0];
      end
   endgenerate

   // State, shift register and bit counter; reset dominates everything.
   always_ff @(posedge SC_RegSERIAL_CLOCK_50) begin
      if (SC_RegSERIAL_RESET_InHigh) begin
         r_state <= IDLE;
         r_shift <= '0;
         r_count <= '0;
      end else begin
         r_state <= w_stateNext;
         r_shift <= w_shiftNext;
         r_count <= w_countNext;
      end
   end

   // Next-state logic: clear beats load, loads are only seen in IDLE.
   always_comb begin
      w_stateNext = r_state;
      w_shiftNext = r_shift;
      w_countNext = r_count;
      if (!SC_RegSERIAL_clear_InLow) begin
         w_stateNext = IDLE;
         w_shiftNext = '0;
         w_countNext = '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (!SC_RegSERIAL_load_InLow) begin
                  w_stateNext = SHIFT;
                  w_shiftNext = SC_RegSERIAL_data_InBUS;
                  w_countNext = '0;
               end
            end
            SHIFT: begin
               w_shiftNext = w_shiftMoved;
               if (r_count == c_LAST) begin
                  w_stateNext = DONE;
                  w_countNext = '0;
               end else begin
                  w_countNext = r_count + 1'b1;
               end
            end
            DONE: begin
               w_stateNext = IDLE;
            end
            default: begin
               w_stateNext = IDLE;
               w_shiftNext = '0;
               w_countNext = '0;
            end
         endcase
      end
   end

   // Outputs depend on registered state only.
   assign SC_RegSERIAL_ready_Out  = (r_state == IDLE);
   assign SC_RegSERIAL_valid_Out  = (r_state == SHIFT);
   assign SC_RegSERIAL_done_Out   = (r_state == DONE);
   assign SC_RegSERIAL_serial_Out = (r_state == SHIFT) ? w_activeBit : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_sc_reg_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sc_reg_serializer
//  Description : Self-checking bench; an MSB-first and an LSB-first instance
//                share stimulus and are compared against a queue-based model
//                of the expected output stream.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sc_reg_serializer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         clrN;
   logic         loadN;
   logic [W-1:0] data;

   logic readyM, serialM, validM, doneM;
   logic readyL, serialL, validL, doneL;

   int checks = 0;
   int errors = 0;

   // One expected output cycle of a transfer
   typedef struct {
      bit v;
      bit sMsb;
      bit sLsb;
      bit d;
   } entry_t;

   entry_t expQ[$];

   always #5 clk = ~clk;

   sc_reg_serializer #(.RegSERIAL_DATAWIDTH(W), .RegSERIAL_MSB_FIRST(1'b1)) u_dutMsb (
      .SC_RegSERIAL_CLOCK_50     (clk),
      .SC_RegSERIAL_RESET_InHigh (rst),
      .SC_RegSERIAL_clear_InLow  (clrN),
      .SC_RegSERIAL_load_InLow   (loadN),
      .SC_RegSERIAL_data_InBUS   (data),
      .SC_RegSERIAL_ready_Out    (readyM),
      .SC_RegSERIAL_serial_Out   (serialM),
      .SC_RegSERIAL_valid_Out    (validM),
      .SC_RegSERIAL_done_Out     (doneM)
   );

   sc_reg_serializer #(.RegSERIAL_DATAWIDTH(W), .RegSERIAL_MSB_FIRST(1'b0)) u_dutLsb (
      .SC_RegSERIAL_CLOCK_50     (clk),
      .SC_RegSERIAL_RESET_InHigh (rst),
      .SC_RegSERIAL_clear_InLow  (clrN),
      .SC_RegSERIAL_load_InLow   (loadN),
      .SC_RegSERIAL_data_InBUS   (data),
      .SC_RegSERIAL_ready_Out    (readyL),
      .SC_RegSERIAL_serial_Out   (serialL),
      .SC_RegSERIAL_valid_Out    (validL),
      .SC_RegSERIAL_done_Out     (doneL)
   );

   // Compare one observed value against its expectation
   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Model: the transfer is a list of W bit cycles plus one done cycle
   task automatic modelEdge(input logic r, input logic c, input logic l, input logic [W-1:0] dIn);
      entry_t e;
      if (r || !c) begin
         expQ.delete();
      end else if (expQ.size() == 0) begin
         if (!l) begin
            for (int i = 0; i < W; i++) begin
               e.v    = 1'b1;
               e.sMsb = dIn[W-1-i];
               e.sLsb = dIn[i];
               e.d    = 1'b0;
               expQ.push_back(e);
            end
            e.v = 1'b0; e.sMsb = 1'b0; e.sLsb = 1'b0; e.d = 1'b1;
            expQ.push_back(e);
         end
      end else begin
         void'(expQ.pop_front());
      end
   endtask

   task automatic checkOutputs();
      logic eReady, eValid, eSerM, eSerL, eDone;
      if (expQ.size() == 0) begin
         eReady = 1'b1; eValid = 1'b0; eSerM = 1'b0; eSerL = 1'b0; eDone = 1'b0;
      end else begin
         eReady = 1'b0;
         eValid = expQ[0].v;
         eSerM  = expQ[0].sMsb;
         eSerL  = expQ[0].sLsb;
         eDone  = expQ[0].d;
      end
      checkVal("readyM",  {31'd0, readyM},  {31'd0, eReady});
      checkVal("validM",  {31'd0, validM},  {31'd0, eValid});
      checkVal("serialM", {31'd0, serialM}, {31'd0, eSerM});
      checkVal("doneM",   {31'd0, doneM},   {31'd0, eDone});
      checkVal("readyL",  {31'd0, readyL},  {31'd0, eReady});
      checkVal("validL",  {31'd0, validL},  {31'd0, eValid});
      checkVal("serialL", {31'd0, serialL}, {31'd0, eSerL});
      checkVal("doneL",   {31'd0, doneL},   {31'd0, eDone});
   endtask

   // Apply inputs for one edge, advance the model, then check outputs
   task automatic step(input logic r, input logic c, input logic l, input logic [W-1:0] dIn);
      rst = r; clrN = c; loadN = l; data = dIn;
      @(posedge clk);
      modelEdge(r, c, l, dIn);
      #1;
      checkOutputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, $urandom);
   endtask

   initial begin
      rst = 1'b1; clrN = 1'b1; loadN = 1'b0; data = 8'h5A;

      // Reset held with load asserted: nothing captured
      step(1'b1, 1'b1, 1'b0, 8'h5A);
      step(1'b1, 1'b1, 1'b0, 8'h5A);
      checkVal("resetReady", {31'd0, readyM}, 32'd1);
      checkVal("resetValid", {31'd0, validM}, 32'd0);
      idle(2);

      // Single word, both bit orders
      step(1'b0, 1'b1, 1'b0, 8'h0D);
      idle(11);

      // Load held low while busy: 8'h00 must not interrupt the 8'hFF word
      step(1'b0, 1'b1, 1'b0, 8'hFF);
      for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
      idle(12);

      // Clear after the 3rd bit, then a clean word
      step(1'b0, 1'b1, 1'b0, 8'hAA);
      idle(2);
      step(1'b0, 1'b0, 1'b1, 8'h00);
      checkVal("clearReady", {31'd0, readyM}, 32'd1);
      step(1'b0, 1'b1, 1'b0, 8'h81);
      idle(11);

      // Reset during bit 5
      step(1'b0, 1'b1, 1'b0, 8'h3C);
      idle(4);
      step(1'b1, 1'b1, 1'b1, 8'h00);
      checkVal("rstMidDone", {31'd0, doneM}, 32'd0);
      idle(2);

      // Clear and load on the same edge in IDLE
      step(1'b0, 1'b0, 1'b0, 8'hC3);
      checkVal("clrLoadValid", {31'd0, validM}, 32'd0);
      idle(2);

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 99) < 2),
              !($urandom_range(0, 99) < 4),
              !($urandom_range(0, 99) < 35),
              W'($urandom));
      end
      idle(12);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sc_reg_serializer.md
Name: sc_reg_serializer

Overview:
- Parallel-in, serial-out transmitter: the read-out counterpart of the general parallel-load register.
- Captures a DATAWIDTH-bit word on an active-low load request, then shifts it out one bit per clock with a bit-valid strobe and a one-cycle done pulse.
- Sits between a general register's output bus and a serial consumer (LED chain, serial link, test pin). One clock domain.

Parameters:
- RegSERIAL_DATAWIDTH, 8, word width in bits; must be >= 2.
- RegSERIAL_MSB_FIRST, 1, 1 = shift MSB first, 0 = shift LSB first.

Ports:
- SC_RegSERIAL_CLOCK_50  input  1  system clock; all state changes on its rising edge.
- SC_RegSERIAL_RESET_InHigh  input  1  reset, synchronous, active-high.
- SC_RegSERIAL_clear_InLow  input  1  abort, active-low (asserted when 0).
- SC_RegSERIAL_load_InLow  input  1  start request, active-low; sampled only when ready=1.
- SC_RegSERIAL_data_InBUS  input  DATAWIDTH  word captured on an accepted load.
- SC_RegSERIAL_ready_Out  output  1  1 = idle, load will be accepted.
- SC_RegSERIAL_serial_Out  output  1  current serial bit; 0 when valid=0.
- SC_RegSERIAL_valid_Out  output  1  1 = serial_Out carries a data bit this cycle.
- SC_RegSERIAL_done_Out  output  1  one-cycle pulse after the last bit.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. The reset port is sampled only on the rising clock edge.
- Reset: forces state IDLE, shift register 0 and bit counter 0.
  - Output values after reset: ready=1, valid=0, serial=0, done=0.
  - Reset overrides clear and load.
  - Reset mid-shift aborts the transfer with no done pulse.
- Internal state:
  - DATAWIDTH-bit shift register.
  - Bit counter, width clog2(DATAWIDTH), zero-based.
  - FSM with states IDLE, SHIFT, DONE.
- Outputs are decoded from registered state only (no input-to-output combinational path).
  - ready = (state==IDLE).
  - valid = (state==SHIFT).
  - done = (state==DONE).
  - serial = valid ? active end bit : 0. The active end bit is the MSB if MSB_FIRST=1, otherwise the LSB.
- Priority at each edge: reset > clear > load.
- IDLE:
  - If load_InLow==0 at edge E0: capture data_InBUS into the shift register, set count=0, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - In the cycle after edge Ei (i = 0..W-1), bit i of the transmit order is on serial_Out with valid=1.
  - At each edge: shift toward the active end (zero fill) and increment count.
  - When count==W-1 at the edge: go to DONE.
  - Exactly W valid cycles, contiguous, no gaps.
- DONE:
  - done=1 and ready=0 for exactly one cycle.
  - At the next edge go to IDLE, unconditionally.
- Latency:
  - First bit appears 1 cycle after the accepting edge.
  - done appears W+1 cycles after the accepting edge.
  - ready returns W+2 cycles after the accepting edge.
  - Minimum spacing between accepted loads is W+2 cycles.
- Load while ready=0 (SHIFT or DONE): ignored, not queued. data_InBUS is don't-care outside the accepting edge.
- clear_InLow==0 in any state: at the next edge go to IDLE with shift register 0 and count 0, and no done pulse.
  - Clear in DONE suppresses nothing, since done has already been shown.
  - Clear and load asserted together in IDLE: clear wins, nothing is captured.
- Load held low continuously: a new word is accepted on every edge where ready=1, i.e. every W+2 cycles.

Test Plan:
- Reset: hold reset 2 cycles with load=0 and clear=1 -> after release ready=1, valid=0, serial=0, done=0. No capture occurs during reset.
- MSB_FIRST=1, W=8, load 8'h0D for one edge -> valid high 8 cycles with serial 0,0,0,0,1,1,0,1; then done=1 for 1 cycle; then ready=1 at cycle 10 after acceptance.
- MSB_FIRST=0, W=8, load 8'h0D -> serial 1,0,1,1,0,0,0,0; then done pulse; identical timing to the MSB-first case.
- Busy load: accept 8'hFF, then drive load=0 with data 8'h00 during SHIFT and DONE -> all 8 bits are 1 and the 8'h00 is never sent. Next load in IDLE is accepted.
- Clear mid-shift: accept 8'hAA, assert clear after the 3rd valid bit -> next cycle valid=0, serial=0, ready=1, no done pulse. A following load of 8'h81 shifts correctly as 1,0,0,0,0,0,0,1.
- Reset mid-shift and simultaneous events:
  - Reset asserted during bit 5 -> next cycle reset outputs and no done.
  - In IDLE, clear=0 and load=0 on the same edge -> stays IDLE with valid=0.
